// File: rtl/bus_pkg.sv
// bus_pkg: shared definitions for the serial bus arbiter, masters and slaves.
//   - FSM state encodings (2 bits): IDLE, DECODE, CONNECT, ERROR
//   - grant encodings: GRANT_NONE, GRANT_M1, GRANT_M2
//   - default slave count and select-bit width
//   - mline_t: one master's request/frame lines bundled for muxing
package bus_pkg;

  localparam int BUS_NUM_SLAVES = 3;
  localparam int BUS_SEL_BITS   = 2;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] DECODE  = 2'd1;
  localparam logic [1:0] CONNECT = 2'd2;
  localparam logic [1:0] ERROR   = 2'd3;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_M1   = 2'b01;
  localparam logic [1:0] GRANT_M2   = 2'b10;

  typedef struct packed {
    logic bus_req;
    logic valid;
    logic addr;
    logic data;
    logic write_en;
    logic burst_mode;
  } mline_t;

endpackage

// File: rtl/addr_sel_decoder.sv
// addr_sel_decoder: collects the leading SEL_BITS serial address bits of a
// frame (MSB first) into a slave select.
//   clock, reset : clock, async active-high reset (sel and count clear to 0)
//   bit_in       : serial address bit of the granted master
//   sample       : high when bit_in is a valid frame bit to be captured
//   sel          : registered select, stable once the decode is done
//   sel_next     : select including the bit captured this cycle
//   done         : high in the cycle the last select bit is captured
module addr_sel_decoder
  import bus_pkg::*;
#(
  parameter int SEL_BITS = BUS_SEL_BITS
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                bit_in,
  input  logic                sample,
  output logic [SEL_BITS-1:0] sel,
  output logic [SEL_BITS-1:0] sel_next,
  output logic                done
);

  localparam int CNT_W = $clog2(SEL_BITS + 1);

  logic [CNT_W-1:0] cnt;

  // Truncating {sel, bit_in} drops the oldest bit, so this also works for SEL_BITS == 1.
  assign sel_next = SEL_BITS'({sel, bit_in});
  assign done     = sample && (cnt == CNT_W'(SEL_BITS - 1));

  // Any gap in sample (valid dropped, or not decoding) restarts the count,
  // which is how a frame aborted mid-select is discarded.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      sel <= '0;
    end else if (sample) begin
      sel <= sel_next;
      cnt <= done ? '0 : cnt + 1'b1;
    end else begin
      cnt <= '0;
    end
  end

endmodule

// File: rtl/serial_bus_arbiter.sv
// serial_bus_arbiter: shares one serial slave bus between two masters.
//   Grants the bus on bus_req (registered bus_ready/grant_id), decodes the
//   leading SEL_BITS address bits of each frame into a slave select, forwards
//   the rest of the frame (one cycle registered) to that slave with a one-hot
//   s_valid, and returns the selected slave's lines combinationally.
// Ports:
//   clock, reset                  : clock, async active-high reset
//   m1_*/m2_* inputs              : bus_req and serial frame lines per master
//   m1_*/m2_* outputs             : bus_ready grant and return path per master
//   s_addr_tx/data_tx/write_en/burst_mode : forwarded lines, shared
//   s_valid[NUM_SLAVES]           : one-hot frame valid
//   s_data_rx/slave_valid/slave_ready[NUM_SLAVES] : per-slave return lines
//   grant_id                      : 00 none, 01 master 1, 10 master 2
//   decode_err                    : one-cycle pulse on a nonexistent slave select
// Build option: define ARB_ROUND_ROBIN_EN to alternate winners on simultaneous
//   requests (master 1 wins the first tie); otherwise master 1 always wins.
module serial_bus_arbiter
  import bus_pkg::*;
#(
  parameter int NUM_SLAVES = BUS_NUM_SLAVES,
  parameter int SEL_BITS   = BUS_SEL_BITS
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  m1_bus_req,
  input  logic                  m1_addr_tx,
  input  logic                  m1_data_tx,
  input  logic                  m1_valid_s,
  input  logic                  m1_write_en,
  input  logic                  m1_burst_mode,
  input  logic                  m2_bus_req,
  input  logic                  m2_addr_tx,
  input  logic                  m2_data_tx,
  input  logic                  m2_valid_s,
  input  logic                  m2_write_en,
  input  logic                  m2_burst_mode,
  output logic                  m1_bus_ready,
  output logic                  m1_data_rx,
  output logic                  m1_slave_valid,
  output logic                  m1_slave_ready,
  output logic                  m2_bus_ready,
  output logic                  m2_data_rx,
  output logic                  m2_slave_valid,
  output logic                  m2_slave_ready,
  output logic                  s_addr_tx,
  output logic                  s_data_tx,
  output logic                  s_write_en,
  output logic                  s_burst_mode,
  output logic [NUM_SLAVES-1:0] s_valid,
  input  logic [NUM_SLAVES-1:0] s_data_rx,
  input  logic [NUM_SLAVES-1:0] s_slave_valid,
  input  logic [NUM_SLAVES-1:0] s_slave_ready,
  output logic [1:0]            grant_id,
  output logic                  decode_err
);

  logic [1:0]            state;
  logic [1:0]            grant;
  logic [1:0]            pick;
  mline_t                m1, m2, g;
  logic [SEL_BITS-1:0]   sel, sel_next;
  logic                  sel_done;
  logic                  sel_in_range;
  logic [NUM_SLAVES-1:0] sel_oh;
  logic                  rx, sv, sr;

  assign m1 = '{bus_req: m1_bus_req, valid: m1_valid_s, addr: m1_addr_tx,
                data: m1_data_tx, write_en: m1_write_en, burst_mode: m1_burst_mode};
  assign m2 = '{bus_req: m2_bus_req, valid: m2_valid_s, addr: m2_addr_tx,
                data: m2_data_tx, write_en: m2_write_en, burst_mode: m2_burst_mode};

  // Lines of whichever master currently holds the grant.
  always_comb begin
    g = '0;
    case (grant)
      GRANT_M1: g = m1;
      GRANT_M2: g = m2;
      default:  g = '0;
    endcase
  end

  addr_sel_decoder #(.SEL_BITS(SEL_BITS)) u_dec (
    .clock    (clock),
    .reset    (reset),
    .bit_in   (g.addr),
    .sample   ((state == DECODE) && g.bus_req && g.valid),
    .sel      (sel),
    .sel_next (sel_next),
    .done     (sel_done)
  );

  // Range check and one-hot by enumeration so no index ever exceeds the port width.
  always_comb begin
    sel_in_range = 1'b0;
    sel_oh       = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (sel_next == SEL_BITS'(i)) sel_in_range = 1'b1;
      sel_oh[i] = (sel == SEL_BITS'(i));
    end
  end

  // Arbitration choice, only acted on in IDLE.
`ifdef ARB_ROUND_ROBIN_EN
  logic [1:0] last_grant;

  always_comb begin
    pick = GRANT_NONE;
    if (m1_bus_req && m2_bus_req)
      pick = (last_grant == GRANT_M1) ? GRANT_M2 : GRANT_M1;
    else if (m1_bus_req)
      pick = GRANT_M1;
    else if (m2_bus_req)
      pick = GRANT_M2;
  end

  // Reset to master 2 so master 1 takes the first tie.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      last_grant <= GRANT_M2;
    else if (state == IDLE && pick != GRANT_NONE)
      last_grant <= pick;
  end
`else
  always_comb begin
    pick = GRANT_NONE;
    if (m1_bus_req)
      pick = GRANT_M1;
    else if (m2_bus_req)
      pick = GRANT_M2;
  end
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      grant        <= GRANT_NONE;
      s_valid      <= '0;
      s_addr_tx    <= 1'b0;
      s_data_tx    <= 1'b0;
      s_write_en   <= 1'b0;
      s_burst_mode <= 1'b0;
      decode_err   <= 1'b0;
    end else begin
      // Slave side is quiet unless CONNECT re-drives it below.
      s_valid      <= '0;
      s_addr_tx    <= 1'b0;
      s_data_tx    <= 1'b0;
      s_write_en   <= 1'b0;
      s_burst_mode <= 1'b0;
      decode_err   <= 1'b0;
      if (state == IDLE) begin
        if (pick != GRANT_NONE) begin
          grant <= pick;
          state <= DECODE;
        end
      end else if (!g.bus_req) begin
        // Release wins over everything else; a new grant needs a cycle in IDLE.
        grant <= GRANT_NONE;
        state <= IDLE;
      end else begin
        case (state)
          DECODE: begin
            if (sel_done) begin
              state      <= sel_in_range ? CONNECT : ERROR;
              decode_err <= !sel_in_range;
            end
          end
          CONNECT: begin
            s_valid      <= g.valid ? sel_oh : '0;
            s_addr_tx    <= g.addr;
            s_data_tx    <= g.data;
            s_write_en   <= g.write_en;
            s_burst_mode <= g.burst_mode;
            if (!g.valid) state <= DECODE;
          end
          ERROR: begin
            if (!g.valid) state <= DECODE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Return path: unregistered, only while connected to an existing slave.
  always_comb begin
    rx = 1'b0;
    sv = 1'b0;
    sr = 1'b0;
    if (state == CONNECT) begin
      for (int i = 0; i < NUM_SLAVES; i++) begin
        if (sel_oh[i]) begin
          rx = s_data_rx[i];
          sv = s_slave_valid[i];
          sr = s_slave_ready[i];
        end
      end
    end
  end

  assign grant_id       = grant;
  assign m1_bus_ready   = (grant == GRANT_M1);
  assign m2_bus_ready   = (grant == GRANT_M2);
  assign m1_data_rx     = m1_bus_ready & rx;
  assign m1_slave_valid = m1_bus_ready & sv;
  assign m1_slave_ready = m1_bus_ready & sr;
  assign m2_data_rx     = m2_bus_ready & rx;
  assign m2_slave_valid = m2_bus_ready & sv;
  assign m2_slave_ready = m2_bus_ready & sr;

endmodule

// File: tb/tb_serial_bus_arbiter.sv
// Self-checking bench for serial_bus_arbiter (NUM_SLAVES=3, SEL_BITS=2).
module tb_serial_bus_arbiter;

  logic       clock = 1'b0;
  logic       reset;
  logic       m1_bus_req, m1_addr_tx, m1_data_tx, m1_valid_s, m1_write_en, m1_burst_mode;
  logic       m2_bus_req, m2_addr_tx, m2_data_tx, m2_valid_s, m2_write_en, m2_burst_mode;
  logic       m1_bus_ready, m1_data_rx, m1_slave_valid, m1_slave_ready;
  logic       m2_bus_ready, m2_data_rx, m2_slave_valid, m2_slave_ready;
  logic       s_addr_tx, s_data_tx, s_write_en, s_burst_mode;
  logic [2:0] s_valid, s_data_rx, s_slave_valid, s_slave_ready;
  logic [1:0] grant_id;
  logic       decode_err;

  serial_bus_arbiter #(.NUM_SLAVES(3), .SEL_BITS(2)) dut (
    .clock(clock), .reset(reset),
    .m1_bus_req(m1_bus_req), .m1_addr_tx(m1_addr_tx), .m1_data_tx(m1_data_tx),
    .m1_valid_s(m1_valid_s), .m1_write_en(m1_write_en), .m1_burst_mode(m1_burst_mode),
    .m2_bus_req(m2_bus_req), .m2_addr_tx(m2_addr_tx), .m2_data_tx(m2_data_tx),
    .m2_valid_s(m2_valid_s), .m2_write_en(m2_write_en), .m2_burst_mode(m2_burst_mode),
    .m1_bus_ready(m1_bus_ready), .m1_data_rx(m1_data_rx),
    .m1_slave_valid(m1_slave_valid), .m1_slave_ready(m1_slave_ready),
    .m2_bus_ready(m2_bus_ready), .m2_data_rx(m2_data_rx),
    .m2_slave_valid(m2_slave_valid), .m2_slave_ready(m2_slave_ready),
    .s_addr_tx(s_addr_tx), .s_data_tx(s_data_tx), .s_write_en(s_write_en),
    .s_burst_mode(s_burst_mode), .s_valid(s_valid),
    .s_data_rx(s_data_rx), .s_slave_valid(s_slave_valid), .s_slave_ready(s_slave_ready),
    .grant_id(grant_id), .decode_err(decode_err)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Scoreboard of forwarded slave-side beats.
  typedef struct packed {
    logic [2:0] v;
    logic       a, d, w, b;
  } fwd_t;

  fwd_t q[$];
  fwd_t got;

  always @(negedge clock) begin
    if (!reset && s_valid != 3'b000) begin
      if (q.size() == 0) begin
        chk("unexpected_s_valid", 32'(s_valid), 32'(0));
      end else begin
        got = q.pop_front();
        chk("fwd_beat", 32'({s_valid, s_addr_tx, s_data_tx, s_write_en, s_burst_mode}), 32'(got));
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_req(input int m, input logic r);
    if (m == 1) m1_bus_req = r; else m2_bus_req = r;
  endtask

  task automatic set_m(input int m, input logic v, a, d, w, b);
    if (m == 1) begin
      m1_valid_s = v; m1_addr_tx = a; m1_data_tx = d; m1_write_en = w; m1_burst_mode = b;
    end else begin
      m2_valid_s = v; m2_addr_tx = a; m2_data_tx = d; m2_write_en = w; m2_burst_mode = b;
    end
  endtask

  function automatic logic rdy(input int m);
    return (m == 1) ? m1_bus_ready : m2_bus_ready;
  endfunction

  task automatic wait_grant(input int m);
    int n = 0;
    while (rdy(m) !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("grant_wait", 32'(rdy(m)), 32'(1));
  endtask

  // One frame: 14 address bits then 8 data-phase bits, valid high throughout.
  // For reads the bench plays the slave and returns rd on the data phase.
  task automatic send_frame(input int m, input logic [13:0] a, input logic [7:0] d,
                            input logic we, input logic bu, input logic err);
    int         slave = int'(a[13:12]);
    logic [2:0] oh    = 3'b001 << slave;
    logic       ab, db, rb;
    logic [7:0] cap   = 8'h00;
    int         nerr  = 0;
    for (int i = 0; i < 22; i++) begin
      ab = (i < 14) ? a[13-i] : 1'b0;
      db = (i >= 14 && we) ? d[21-i] : 1'b0;
      rb = (i >= 14) ? d[21-i] : 1'b0;
      set_m(m, 1'b1, ab, db, we, bu);
      if (!err && i >= 2) q.push_back('{v: oh, a: ab, d: db, w: we, b: bu});
      if (i >= 14 && err) s_slave_valid = 3'b111;
      if (i >= 14 && !err && !we) begin
        s_data_rx[slave]     = rb;
        s_slave_valid[slave] = 1'b1;
        s_slave_ready[slave] = 1'b1;
      end
      @(negedge clock);
      if (i >= 14 && !err && !we) begin
        chk("rx_slave_valid", 32'((m == 1) ? m1_slave_valid : m2_slave_valid), 32'(1));
        chk("rx_other_quiet", 32'((m == 1) ? m2_slave_valid : m1_slave_valid), 32'(0));
        cap = {cap[6:0], (m == 1) ? m1_data_rx : m2_data_rx};
      end
      if (i == 20 && err)
        chk("err_return_zero", 32'((m == 1) ? m1_slave_valid : m2_slave_valid), 32'(0));
      if (decode_err) nerr++;
      tick();
    end
    s_data_rx = 3'b000; s_slave_valid = 3'b000; s_slave_ready = 3'b000;
    set_m(m, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clock);
      if (decode_err) nerr++;
      tick();
    end
    chk("beats_drained", 32'(q.size()), 32'(0));
    q.delete();
    if (!we && !err) chk("read_byte", 32'(cap), 32'(d));
    chk("decode_err_pulses", 32'(nerr), err ? 32'(1) : 32'(0));
  endtask

  typedef struct {
    int          m;
    logic [13:0] a;
    logic [7:0]  d;
    logic        we, bu, err;
  } vec_t;

  vec_t vecs[4];

  initial begin
    vecs[0] = '{m: 2, a: 14'b10_0000_0001_0101, d: 8'hA5, we: 1'b1, bu: 1'b0, err: 1'b0};
    vecs[1] = '{m: 1, a: 14'b01_1100_0011_1010, d: 8'h3C, we: 1'b0, bu: 1'b0, err: 1'b0};
    vecs[2] = '{m: 1, a: 14'b00_1010_1010_1111, d: 8'h5A, we: 1'b1, bu: 1'b1, err: 1'b0};
    vecs[3] = '{m: 2, a: 14'b11_0000_0000_0001, d: 8'h00, we: 1'b1, bu: 1'b0, err: 1'b1};

    reset = 1'b1;
    m1_bus_req = 0; m2_bus_req = 0;
    set_m(1, 0, 0, 0, 0, 0);
    set_m(2, 0, 0, 0, 0, 0);
    s_data_rx = 0; s_slave_valid = 0; s_slave_ready = 0;
    repeat (3) @(negedge clock);
    chk("reset_outputs", 32'({m1_bus_ready, m2_bus_ready, grant_id, s_valid, decode_err,
                              s_addr_tx, s_data_tx}), 32'(0));
    tick();
    reset = 1'b0;
    repeat (8) tick();

    // Single requester: grant registered one cycle after the request is sampled.
    m1_bus_req = 1'b1;
    @(negedge clock);
    chk("m1_ready_not_yet", 32'(m1_bus_ready), 32'(0));
    tick();
    @(negedge clock);
    chk("m1_only_grant", 32'({m1_bus_ready, m2_bus_ready, grant_id}), 32'({2'b10, 2'b01}));
    tick();
    m1_bus_req = 1'b0;
    tick();
    @(negedge clock);
    chk("m1_release", 32'(grant_id), 32'(0));

    // Tie right after reset: master 1 first in either arbitration mode.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    m1_bus_req = 1'b1; m2_bus_req = 1'b1;
    tick();
    @(negedge clock);
    chk("tie_m1_wins", 32'(grant_id), 32'(2'b01));
    repeat (5) tick();
    m1_bus_req = 1'b0;
    tick();
    @(negedge clock);
    chk("handoff_gap", 32'(grant_id), 32'(0));
    tick();
    @(negedge clock);
    chk("handoff_m2", 32'({m1_bus_ready, m2_bus_ready, grant_id}), 32'({2'b01, 2'b10}));
    tick();
    m2_bus_req = 1'b0;
    tick();
    tick();

    // Table-driven frames, each under its own grant.
    for (int v = 0; v < 4; v++) begin
      set_req(vecs[v].m, 1'b1);
      wait_grant(vecs[v].m);
      send_frame(vecs[v].m, vecs[v].a, vecs[v].d, vecs[v].we, vecs[v].bu, vecs[v].err);
      set_req(vecs[v].m, 1'b0);
      tick();
      @(negedge clock);
      chk("release_drop", 32'(grant_id), 32'(0));
      tick();
    end

    // Two frames under one grant target different slaves (re-decode per frame).
    m1_bus_req = 1'b1;
    wait_grant(1);
    send_frame(1, 14'b10_1111_0000_1111, 8'hC3, 1'b1, 1'b1, 1'b0);
    send_frame(1, 14'b00_0101_0101_0101, 8'h96, 1'b1, 1'b1, 1'b0);
    m1_bus_req = 1'b0;
    tick();
    tick();

    // Aborted select: one bit then valid drops; next frame must decode cleanly.
    m2_bus_req = 1'b1;
    wait_grant(2);
    set_m(2, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    set_m(2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    send_frame(2, 14'b00_1110_0001_1011, 8'h3E, 1'b1, 1'b0, 1'b0);
    chk("abort_grant_kept", 32'(grant_id), 32'(2'b10));
    m2_bus_req = 1'b0;
    tick();
    tick();

    // Reset in the middle of CONNECT.
    m1_bus_req = 1'b1;
    wait_grant(1);
    s_slave_valid = 3'b001;
    for (int i = 0; i < 6; i++) begin
      set_m(1, 1'b1, (i >= 2), 1'b0, 1'b1, 1'b0);
      if (i >= 2) q.push_back('{v: 3'b001, a: 1'b1, d: 1'b0, w: 1'b1, b: 1'b0});
      tick();
    end
    @(negedge clock);
    chk("connect_return", 32'(m1_slave_valid), 32'(1));
    #2;
    reset = 1'b1;
    #1;
    chk("async_reset_outputs", 32'({m1_bus_ready, grant_id, s_valid, s_addr_tx, s_write_en,
                                    m1_slave_valid}), 32'(0));
    q.delete();
    s_slave_valid = 3'b000;
    set_m(1, 0, 0, 0, 0, 0);
    tick();
    reset = 1'b0;
    wait_grant(1);
    chk("post_reset_grant", 32'(grant_id), 32'(2'b01));
    m1_bus_req = 1'b0;
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
